addr_cal: RTL and testbench
===========================

ADDR_CAL -- requirements
Module: addr_cal

Interface
- REQ-001: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-002: reset  input  1  asynchronous, active-low reset.
- REQ-003: pattern_info  input  80  pattern descriptor, fields as follows.
  - [79:64] base address.
  - [63:48] tile width TW.
  - [47:32] tile height TH.
  - [31:16] total width W.
  - [15:0] total height H.
- REQ-004: sprite_info  input  32  sprite state, fields as follows.
  - [31] visible.
  - [30] flip.
  - [29:20] x.
  - [19:10] y.
  - [9:0] shift (horizontal scroll).
- REQ-005: hcount  input  10  current pixel column.
- REQ-006: vcount  input  10  current pixel row.
- REQ-007: addr_output  output  16  sprite-memory address for the current pixel.
- REQ-008: valid  output  1  current pixel lies inside a visible sprite.

Function
- REQ-009: Effective left edge EX = x - shift, computed as 12-bit signed; a negative EX is legal (sprite partly off-screen left).
- REQ-010: dx = hcount - EX and dy = vcount - y, both 12-bit signed.
- REQ-011: Hit condition: visible=1 AND 0 <= dx < W AND 0 <= dy < H.
  - Comparisons use at least 17-bit unsigned-extended arithmetic, so no wrap-around.
- REQ-012: Local coordinates: lx = dx AND (TW-1), ly = dy AND (TH-1).
  - TW and TH are powers of two, 1..128.
  - Non-power-of-two values give this masked result; no error is flagged.
- REQ-013: When flip=1, lx is replaced by (TW-1) - lx.
- REQ-014: On hit, the address is base + ly*TW + lx, truncated to 16 bits (wraps modulo 65536).
- REQ-015: On no hit, addr_output = 0 and valid = 0.
- REQ-016: Outputs are registered with latency of exactly 1 clk.
  - The values computed from the inputs sampled at edge N appear after edge N.
  - Inputs may change every cycle; there is no handshake and no stall.
- REQ-017: W=0 or H=0 never produces a hit.
- REQ-018: Hit region boundaries: hcount = EX+W-1 hits; hcount = EX+W does not; vcount likewise against y+H.
- REQ-019: The block holds no state other than the output registers.

Reset
- REQ-020: While reset=0, addr_output=0 and valid=0, asynchronously and regardless of clk.
- REQ-021: After reset deasserts, the first rising edge of clk loads normally computed outputs.
- REQ-022: Reset asserted mid-frame clears the outputs immediately; no residual state remains.

Configuration
- REQ-023: Macro ADDR_CAL_FLIP_EN controls horizontal flip support.
  - Defined: flip per REQ-013.
  - Undefined: sprite_info[30] is ignored and lx is never mirrored.
  - All other behaviour is identical.

Verification
- REQ-024: Basic hit. pattern {256,16,16,16,16}, visible, x=100, y=50, shift=0, hcount=103, vcount=52 -> one cycle later addr_output=291, valid=1.
- REQ-025: Flip. Same stimulus with flip=1 and ADDR_CAL_FLIP_EN defined -> addr_output=300; with the macro undefined -> addr_output=291.
- REQ-026: Tiling edge. pattern {1280,16,16,48,16}, x=0, y=0.
  - hcount=37, vcount=5 -> addr_output=1365, valid=1.
  - hcount=47 -> valid=1.
  - hcount=48 -> valid=0, addr_output=0.
- REQ-027: Scroll. pattern {256,16,16,16,16}, x=10, shift=20, y=0, hcount=0, vcount=0 -> addr_output=266, valid=1.
- REQ-028: Invisible. REQ-024 stimulus with visible=0 -> valid=0, addr_output=0.
- REQ-029: Reset. Assert reset=0 while valid=1, between clock edges -> outputs go to 0 immediately. Release -> the next edge restores the REQ-024 result.

Source files
------------

// File: rtl/addr_cal.sv
// Sprite address calculator: maps the current pixel to a sprite-memory address, registered once.
// Optional macro ADDR_CAL_FLIP_EN enables horizontal mirroring via sprite_info[30].
module addr_cal (
  input  logic        clk,
  input  logic        reset,
  input  logic [79:0] pattern_info,
  input  logic [31:0] sprite_info,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [15:0] addr_output,
  output logic        valid
);

`ifdef ADDR_CAL_FLIP_EN
  localparam logic FLIP_EN = 1'b1;
`else
  localparam logic FLIP_EN = 1'b0;
`endif

  logic [15:0] base, tile_w, tile_h, tot_w, tot_h;
  logic        visible, flip;
  logic [9:0]  spr_x, spr_y, shift;

  assign base    = pattern_info[79:64];
  assign tile_w  = pattern_info[63:48];
  assign tile_h  = pattern_info[47:32];
  assign tot_w   = pattern_info[31:16];
  assign tot_h   = pattern_info[15:0];
  assign visible = sprite_info[31];
  assign flip    = sprite_info[30];
  assign spr_x   = sprite_info[29:20];
  assign spr_y   = sprite_info[19:10];
  assign shift   = sprite_info[9:0];

  logic [11:0] eff_x, dx, dy;
  logic        in_x, in_y, hit;
  logic [15:0] tw_m1, th_m1, lx_raw, lx, ly;
  logic [15:0] addr_d, addr_q;
  logic        valid_d, valid_q;

  // 12-bit signed offsets; a set sign bit means the pixel is left of / above the sprite
  always_comb begin
    eff_x   = {2'b00, spr_x} - {2'b00, shift};
    dx      = {2'b00, hcount} - eff_x;
    dy      = {2'b00, vcount} - {2'b00, spr_y};
    in_x    = ~dx[11] && ({5'b00000, dx} < {1'b0, tot_w});
    in_y    = ~dy[11] && ({5'b00000, dy} < {1'b0, tot_h});
    hit     = visible && in_x && in_y;
    tw_m1   = tile_w - 16'd1;
    th_m1   = tile_h - 16'd1;
    lx_raw  = {4'b0000, dx} & tw_m1;
    ly      = {4'b0000, dy} & th_m1;
    lx      = (FLIP_EN & flip) ? (tw_m1 - lx_raw) : lx_raw;
    valid_d = hit;
    addr_d  = hit ? (base + ly * tile_w + lx) : 16'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= 16'd0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign addr_output = addr_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_addr_cal.sv
// Scoreboard bench for addr_cal: stimulus pushes model results, a monitor pops and compares.
module tb_addr_cal;
  logic        clk = 1'b0;
  logic        reset;
  logic [79:0] pattern_info;
  logic [31:0] sprite_info;
  logic [9:0]  hcount, vcount;
  logic [15:0] addr_output;
  logic        valid;

  addr_cal dut (
    .clk          (clk),
    .reset        (reset),
    .pattern_info (pattern_info),
    .sprite_info  (sprite_info),
    .hcount       (hcount),
    .vcount       (vcount),
    .addr_output  (addr_output),
    .valid        (valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        vld;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [79:0] pat(input int base, input int tw, input int th,
                                      input int w, input int h);
    return {base[15:0], tw[15:0], th[15:0], w[15:0], h[15:0]};
  endfunction

  function automatic logic [31:0] spr(input int vis, input int fl, input int x,
                                      input int y, input int sh);
    return {vis[0], fl[0], x[9:0], y[9:0], sh[9:0]};
  endfunction

  // Reference: plain integer arithmetic straight from the sprite rules
  function automatic exp_t model(input logic [79:0] p, input logic [31:0] s,
                                 input logic [9:0] hc, input logic [9:0] vc);
    exp_t   e;
    int     base, tw, th, w, h, x, y, sh, ex, dx, dy, lx, ly;
    bit     vis, fl, hit;
    longint a;
    base = int'(p[79:64]); tw = int'(p[63:48]); th = int'(p[47:32]);
    w    = int'(p[31:16]); h  = int'(p[15:0]);
    vis  = s[31];          fl = s[30];
    x    = int'(s[29:20]); y  = int'(s[19:10]); sh = int'(s[9:0]);
    ex   = x - sh;
    dx   = int'(hc) - ex;
    dy   = int'(vc) - y;
    hit  = vis && dx >= 0 && dx < w && dy >= 0 && dy < h;
    e.name = "";
    if (!hit) begin
      e.addr = 16'd0;
      e.vld  = 1'b0;
    end else begin
      lx = dx & (tw - 1);
      ly = dy & (th - 1);
`ifdef ADDR_CAL_FLIP_EN
      if (fl) lx = (tw - 1) - lx;
`endif
      a = longint'(base) + longint'(ly) * longint'(tw) + longint'(lx);
      a = a & 64'hFFFF;
      e.addr = a[15:0];
      e.vld  = 1'b1;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [15:0] ea, input logic ev);
    n_vec++;
    if (addr_output !== ea || valid !== ev) begin
      n_err++;
      $display("FAIL %s: got addr=%0d valid=%0b, expected addr=%0d valid=%0b",
               name, addr_output, valid, ea, ev);
    end
  endtask

  task automatic apply(input logic [79:0] p, input logic [31:0] s,
                       input logic [9:0] hc, input logic [9:0] vc, input string name);
    exp_t e;
    @(negedge clk);
    pattern_info = p;
    sprite_info  = s;
    hcount       = hc;
    vcount       = vc;
    e      = model(p, s, hc, vc);
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 6 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d results never appeared, expected 0 pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (reset && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, e.addr, e.vld);
    end
  end

  initial begin
    logic [79:0] p24, p26;
    logic [31:0] s24;
    int tw, th, w, h, x, y, sh, ex, hc, vc;

    p24 = pat(256, 16, 16, 16, 16);
    s24 = spr(1, 0, 100, 50, 0);
    p26 = pat(1280, 16, 16, 48, 16);

    reset        = 1'b0;
    pattern_info = p24;
    sprite_info  = s24;
    hcount       = 10'd103;
    vcount       = 10'd52;
    #12;
    check("reset_state", 16'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    apply(p24, s24, 10'd103, 10'd52, "basic_hit");
    apply(p24, spr(1, 1, 100, 50, 0), 10'd103, 10'd52, "flip");
    apply(p26, spr(1, 0, 0, 0, 0), 10'd37, 10'd5, "tile_37");
    apply(p26, spr(1, 0, 0, 0, 0), 10'd47, 10'd5, "tile_last_col");
    apply(p26, spr(1, 0, 0, 0, 0), 10'd48, 10'd5, "tile_past_col");
    apply(p26, spr(1, 0, 0, 0, 0), 10'd37, 10'd15, "tile_last_row");
    apply(p26, spr(1, 0, 0, 0, 0), 10'd37, 10'd16, "tile_past_row");
    apply(p24, spr(1, 0, 10, 0, 20), 10'd0, 10'd0, "scroll");
    apply(p24, spr(0, 0, 100, 50, 0), 10'd103, 10'd52, "invisible");
    apply(pat(256, 16, 16, 0, 16), s24, 10'd100, 10'd50, "zero_w");
    apply(pat(256, 16, 16, 16, 0), s24, 10'd100, 10'd50, "zero_h");
    apply(p24, s24, 10'd99, 10'd52, "left_of_sprite");
    apply(pat(16'hFFF0, 16, 16, 16, 16), s24, 10'd115, 10'd65, "addr_wrap");
    apply(pat(256, 12, 16, 32, 16), s24, 10'd120, 10'd52, "non_pow2_tw");
    drain();

    // Reset asserted between edges while valid is high
    apply(p24, s24, 10'd103, 10'd52, "pre_reset");
    drain();
    #2;
    reset = 1'b0;
    #1;
    check("reset_async", 16'd0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_hold", 16'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", 16'd291, 1'b1);

    for (int n = 0; n < 400; n++) begin
      tw = 1 << $urandom_range(0, 7);
      th = 1 << $urandom_range(0, 7);
      if ($urandom_range(0, 9) == 0) tw = $urandom_range(0, 200);
      w  = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 300);
      h  = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 300);
      x  = $urandom_range(0, 1023);
      y  = $urandom_range(0, 1023);
      sh = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 1023);
      ex = x - sh;
      hc = ex + $urandom_range(0, w + 10) - 5;
      vc = y + $urandom_range(0, h + 10) - 5;
      if (hc < 0 || hc > 1023) hc = $urandom_range(0, 1023);
      if (vc < 0 || vc > 1023) vc = $urandom_range(0, 1023);
      apply(pat($urandom_range(0, 65535), tw, th, w, h),
            spr(($urandom_range(0, 6) != 0) ? 1 : 0, $urandom_range(0, 1), x, y, sh),
            hc[9:0], vc[9:0], "random");
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
